// File: rtl/cpu_flag_pkg.sv
// ---------------------------------------------------------------------------
// cpu_flag_pkg
// Shared definitions for the CPU status-flag path (ALU, flag unit, branch
// unit). Holds the flag bit positions, the default flag-word width and the
// flag-word type.
// ---------------------------------------------------------------------------
package cpu_flag_pkg;

   // Bit positions of the architectural flags inside the flag word.
   localparam int FLAG_C = 0;  // carry
   localparam int FLAG_Z = 1;  // zero
   localparam int FLAG_B = 2;  // borrow
   localparam int FLAG_V = 3;  // overflow

   // Default flag-word width; modules may override it through a parameter.
   localparam int NFLAGS_DEF = 4;

   typedef logic [NFLAGS_DEF-1:0] flags_t;

endpackage : cpu_flag_pkg

// File: rtl/cpu_flag_stack.sv
// ---------------------------------------------------------------------------
// cpu_flag_stack
// DEPTH-entry LIFO of flag words used to save/restore FLAGS around calls and
// interrupts. Supports push, pop and a same-cycle push+pop swap of the top
// entry. Illegal requests leave the stack untouched and raise a one-cycle
// err pulse.
//
// Ports:
//   CLK, RST_N  clock, asynchronous active-low reset (level only)
//   push, pop   stack requests for this cycle
//   wdata       flag word to save (pre-edge FLAGS of the owner)
//   top         entry at level-1 (meaningless while empty)
//   level       number of occupied entries
//   full, empty decoded from the level register
//   pop_ok      a pop or swap is accepted this cycle; top is the restore value
//   err         push when full, pop when empty, or push+pop when empty
// ---------------------------------------------------------------------------
module cpu_flag_stack #(
   parameter int NFLAGS = 4,
   parameter int DEPTH  = 4
) (
   input  logic                       CLK,
   input  logic                       RST_N,
   input  logic                       push,
   input  logic                       pop,
   input  logic [NFLAGS-1:0]          wdata,
   output logic [NFLAGS-1:0]          top,
   output logic [$clog2(DEPTH+1)-1:0] level,
   output logic                       full,
   output logic                       empty,
   output logic                       pop_ok,
   output logic                       err
);

   localparam int LW = $clog2(DEPTH+1);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [NFLAGS-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_idx;
   logic [AW-1:0]     top_idx;
   logic              push_ok;
   logic              swap;

   assign empty   = (level == '0);
   assign full    = (level == LW'(DEPTH));

   // A pop (alone or as part of a swap) only needs a non-empty stack; a lone
   // push needs a free entry. Push+pop on a full stack is a legal swap.
   assign pop_ok  = pop && !empty;
   assign push_ok = push && !pop && !full;
   assign swap    = push && pop && !empty;
   assign err     = (push && !pop && full) || (pop && empty);

   assign wr_idx  = AW'(level);
   assign top_idx = AW'(level - LW'(1));
   assign top     = mem[top_idx];

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         level <= '0;
      end else if (push_ok) begin
         level <= level + LW'(1);
      end else if (pop_ok && !swap) begin
         level <= level - LW'(1);
      end
   end

   // NOTE: storage has no reset; entries are only ever read after being
   // written, because a pop from an empty stack is blocked.
   always_ff @(posedge CLK) begin
      if (push_ok) begin
         mem[wr_idx] <= wdata;
      end else if (swap) begin
         mem[top_idx] <= wdata;
      end
   end

endmodule : cpu_flag_stack

// File: rtl/cpu_flag_unit.sv
// ---------------------------------------------------------------------------
// cpu_flag_unit
// Registered status-flag word with per-flag write enables, per-flag sticky
// (OR-accumulate) mode, synchronous clear, and a save/restore LIFO.
//
// Ports:
//   CLK, RST_N  clock, asynchronous active-low reset
//   FLAG_IN     new flag values from the ALU
//   FLAG_WE     per-flag write enable
//   STICKY      per-flag mode: 1 = OR into FLAGS, 0 = overwrite
//   CLR         synchronous clear of all flags
//   PUSH, POP   save FLAGS / restore FLAGS (both = swap with top entry)
//   FLAGS       registered flag word
//   LEVEL       occupied stack entries
//   EMPTY, FULL stack status, decoded from LEVEL
//   STK_ERR     sticky illegal push/pop indicator, cleared only by reset
// ---------------------------------------------------------------------------
module cpu_flag_unit
   import cpu_flag_pkg::*;
#(
   parameter int NFLAGS = NFLAGS_DEF,
   parameter int DEPTH  = 4
) (
   input  logic                       CLK,
   input  logic                       RST_N,
   input  logic [NFLAGS-1:0]          FLAG_IN,
   input  logic [NFLAGS-1:0]          FLAG_WE,
   input  logic [NFLAGS-1:0]          STICKY,
   input  logic                       CLR,
   input  logic                       PUSH,
   input  logic                       POP,
   output logic [NFLAGS-1:0]          FLAGS,
   output logic [$clog2(DEPTH+1)-1:0] LEVEL,
   output logic                       EMPTY,
   output logic                       FULL,
   output logic                       STK_ERR
);

   logic [NFLAGS-1:0] stk_top;
   logic [NFLAGS-1:0] upd_val;
   logic [NFLAGS-1:0] flags_nxt;
   logic              pop_ok;
   logic              err_pulse;

   cpu_flag_stack #(
      .NFLAGS (NFLAGS),
      .DEPTH  (DEPTH)
   ) u_stack (
      .CLK    (CLK),
      .RST_N  (RST_N),
      .push   (PUSH),
      .pop    (POP),
      .wdata  (FLAGS),
      .top    (stk_top),
      .level  (LEVEL),
      .full   (FULL),
      .empty  (EMPTY),
      .pop_ok (pop_ok),
      .err    (err_pulse)
   );

   // Per-bit write value: sticky bits accumulate into the current value.
   assign upd_val = FLAG_IN | (FLAGS & STICKY);

   // Restore beats clear, clear beats per-flag writes, unwritten bits hold.
   // NOTE: every always_comb output gets a default first so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      flags_nxt = FLAGS;
      if (pop_ok) begin
         flags_nxt = stk_top;
      end else if (CLR) begin
         flags_nxt = '0;
      end else begin
         flags_nxt = (FLAGS & ~FLAG_WE) | (upd_val & FLAG_WE);
      end
   end

   // NOTE: registers use non-blocking assignments so every flop samples the
   // pre-edge values regardless of block ordering.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         FLAGS   <= '0;
         STK_ERR <= 1'b0;
      end else begin
         FLAGS   <= flags_nxt;
         STK_ERR <= STK_ERR | err_pulse;
      end
   end

endmodule : cpu_flag_unit

// File: tb/tb_cpu_flag_unit.sv
// ---------------------------------------------------------------------------
// tb_cpu_flag_unit
// Directed, table-driven bench for cpu_flag_unit with NFLAGS=4, DEPTH=2.
// ---------------------------------------------------------------------------
module tb_cpu_flag_unit;

   localparam int NF = 4;
   localparam int DP = 2;
   localparam int LW = $clog2(DP+1);

   logic          CLK;
   logic          RST_N;
   logic [NF-1:0] FLAG_IN;
   logic [NF-1:0] FLAG_WE;
   logic [NF-1:0] STICKY;
   logic          CLR;
   logic          PUSH;
   logic          POP;
   logic [NF-1:0] FLAGS;
   logic [LW-1:0] LEVEL;
   logic          EMPTY;
   logic          FULL;
   logic          STK_ERR;

   int n_checks = 0;
   int n_fail   = 0;

   cpu_flag_unit #(
      .NFLAGS (NF),
      .DEPTH  (DP)
   ) dut (
      .CLK     (CLK),
      .RST_N   (RST_N),
      .FLAG_IN (FLAG_IN),
      .FLAG_WE (FLAG_WE),
      .STICKY  (STICKY),
      .CLR     (CLR),
      .PUSH    (PUSH),
      .POP     (POP),
      .FLAGS   (FLAGS),
      .LEVEL   (LEVEL),
      .EMPTY   (EMPTY),
      .FULL    (FULL),
      .STK_ERR (STK_ERR)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef struct {
      string         name;
      logic [NF-1:0] fin;
      logic [NF-1:0] we;
      logic [NF-1:0] st;
      logic          clr;
      logic          push;
      logic          pop;
      logic [NF-1:0] e_flags;
      logic [LW-1:0] e_level;
      logic          e_empty;
      logic          e_full;
      logic          e_err;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_all(input string name, input logic [NF-1:0] f, input logic [LW-1:0] l,
                            input logic e, input logic fu, input logic er);
      check({name, ".flags"},   32'(FLAGS),   32'(f));
      check({name, ".level"},   32'(LEVEL),   32'(l));
      check({name, ".empty"},   32'(EMPTY),   32'(e));
      check({name, ".full"},    32'(FULL),    32'(fu));
      check({name, ".stk_err"}, 32'(STK_ERR), 32'(er));
   endtask

   task automatic drive(input logic [NF-1:0] fin, input logic [NF-1:0] we, input logic [NF-1:0] st,
                        input logic clr, input logic push, input logic pop);
      FLAG_IN = fin;
      FLAG_WE = we;
      STICKY  = st;
      CLR     = clr;
      PUSH    = push;
      POP     = pop;
   endtask

   // Inputs are applied 1 ns after a rising edge and outputs sampled 1 ns
   // after the next one.
   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   vec_t vecs[$];

   initial begin
      vecs = '{
         '{"overwrite",      4'b1011, 4'b1111, 4'b0000, 0, 0, 0, 4'b1011, 2'd0, 1, 0, 0},
         '{"clr0",           4'b0000, 4'b0000, 4'b0000, 1, 0, 0, 4'b0000, 2'd0, 1, 0, 0},
         '{"sticky_set",     4'b0001, 4'b0001, 4'b0001, 0, 0, 0, 4'b0001, 2'd0, 1, 0, 0},
         '{"sticky_hold",    4'b0000, 4'b0001, 4'b0001, 0, 0, 0, 4'b0001, 2'd0, 1, 0, 0},
         '{"clr1",           4'b0000, 4'b0000, 4'b0000, 1, 0, 0, 4'b0000, 2'd0, 1, 0, 0},
         '{"clr_beats_we",   4'b1111, 4'b1111, 4'b0000, 1, 0, 0, 4'b0000, 2'd0, 1, 0, 0},
         '{"write0101",      4'b0101, 4'b1111, 4'b0000, 0, 0, 0, 4'b0101, 2'd0, 1, 0, 0},
         '{"push_wr",        4'b1010, 4'b1111, 4'b0000, 0, 1, 0, 4'b1010, 2'd1, 0, 0, 0},
         '{"pop_restore",    4'b0000, 4'b0000, 4'b0000, 0, 0, 1, 4'b0101, 2'd0, 1, 0, 0},
         '{"write0001",      4'b0001, 4'b1111, 4'b0000, 0, 0, 0, 4'b0001, 2'd0, 1, 0, 0},
         '{"push1",          4'b0000, 4'b0000, 4'b0000, 0, 1, 0, 4'b0001, 2'd1, 0, 0, 0},
         '{"write0010",      4'b0010, 4'b1111, 4'b0000, 0, 0, 0, 4'b0010, 2'd1, 0, 0, 0},
         '{"push2_full",     4'b0000, 4'b0000, 4'b0000, 0, 1, 0, 4'b0010, 2'd2, 0, 1, 0},
         '{"push_overflow",  4'b0100, 4'b1111, 4'b0000, 0, 1, 0, 4'b0100, 2'd2, 0, 1, 1},
         '{"pop_a",          4'b0000, 4'b0000, 4'b0000, 0, 0, 1, 4'b0010, 2'd1, 0, 0, 1},
         '{"pop_b",          4'b0000, 4'b0000, 4'b0000, 0, 0, 1, 4'b0001, 2'd0, 1, 0, 1},
         '{"write0110",      4'b0110, 4'b1111, 4'b0000, 0, 0, 0, 4'b0110, 2'd0, 1, 0, 1},
         '{"push_wr1001",    4'b1001, 4'b1111, 4'b0000, 0, 1, 0, 4'b1001, 2'd1, 0, 0, 1},
         '{"swap_we_ignored",4'b1111, 4'b1111, 4'b0000, 1, 1, 1, 4'b0110, 2'd1, 0, 0, 1},
         '{"pop_after_swap", 4'b0000, 4'b0000, 4'b0000, 0, 0, 1, 4'b1001, 2'd0, 1, 0, 1},
         '{"pop_underflow",  4'b0000, 4'b0000, 4'b0000, 0, 0, 1, 4'b1001, 2'd0, 1, 0, 1}
      };

      // Asynchronous reset asserted mid-cycle, visible without a clock edge.
      RST_N = 1'b1;
      drive('0, '0, '0, 0, 0, 0);
      #2 RST_N = 1'b0;
      #1;
      check_all("reset_async", 4'b0000, 2'd0, 1, 0, 0);
      @(negedge CLK);
      @(negedge CLK);
      RST_N = 1'b1;
      @(posedge CLK);
      #1;

      foreach (vecs[i]) begin
         drive(vecs[i].fin, vecs[i].we, vecs[i].st, vecs[i].clr, vecs[i].push, vecs[i].pop);
         step();
         check_all(vecs[i].name, vecs[i].e_flags, vecs[i].e_level,
                   vecs[i].e_empty, vecs[i].e_full, vecs[i].e_err);
      end

      // Fill the stack, then reset in the middle of a push.
      drive('0, '0, '0, 0, 1, 0);
      step();
      step();
      check_all("refill", 4'b1001, 2'd2, 0, 1, 1);
      #3 RST_N = 1'b0;
      #1;
      check_all("reset_mid_push", 4'b0000, 2'd0, 1, 0, 0);
      @(negedge CLK);
      RST_N = 1'b1;
      drive('0, '0, '0, 0, 0, 1);
      @(posedge CLK);
      #1;
      check_all("pop_after_reset", 4'b0000, 2'd0, 1, 0, 1);

      // Push+pop on an empty stack is an error and leaves FLAGS to the
      // ordinary update path.
      RST_N = 1'b0;
      #1;
      check_all("reset_again", 4'b0000, 2'd0, 1, 0, 0);
      @(negedge CLK);
      RST_N = 1'b1;
      drive(4'b0011, 4'b0011, '0, 0, 1, 1);
      @(posedge CLK);
      #1;
      check_all("swap_empty", 4'b0011, 2'd0, 1, 0, 1);

      drive('0, '0, '0, 0, 0, 0);
      step();
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule : tb_cpu_flag_unit
